// File: rtl/trig_pkg.sv
// Shared definitions for the trig scheduler: default operand format, scaled
// angle constants and the scheduler state type.
package trig_pkg;

   localparam int INT_BITS_DEF = 4;
   localparam int DEC_BITS_DEF = 8;

   // pi/2 in Q16 (102944), rescaled to decBits fractional bits with rounding
   function automatic int piHalfScaled(input int decBits);
      return int'(((longint'(102944) << decBits) + longint'(32768)) >>> 16);
   endfunction

   localparam int PI_HALF = piHalfScaled(DEC_BITS_DEF);
   localparam int TWO_PI  = 4 * PI_HALF;

   typedef enum logic {
      IDLE = 1'b0,
      EVAL = 1'b1
   } state_t;

endpackage

// File: rtl/Cosine.sv
// Combinational fixed-point cosine: folds the angle into [0, pi/2] and
// evaluates a 6th-order Taylor polynomial there.
module Cosine
   import trig_pkg::*;
#(
   parameter int INT_BITS = INT_BITS_DEF,
   parameter int DEC_BITS = DEC_BITS_DEF
) (
   input  logic signed [INT_BITS+DEC_BITS:0] i_x,
   output logic signed [DEC_BITS+1:0]        o_y
);

   localparam longint ONE     = longint'(1) << DEC_BITS;
   localparam longint PI_HALF_L = longint'(piHalfScaled(DEC_BITS));
   localparam longint PI_L      = 2 * PI_HALF_L;
   localparam longint TWO_PI_L  = 4 * PI_HALF_L;

   longint w_a;
   longint w_r;
   longint w_t2;
   longint w_t4;
   longint w_t6;
   longint w_mag;
   logic   w_neg;

   // cos is even and 2*pi periodic; the second quadrant mirrors the first with a sign flip
   always_comb begin
      w_a = longint'(i_x);
      if (w_a < 0) begin
         w_a = -w_a;
      end
      w_r = w_a % TWO_PI_L;
      if (w_r > PI_L) begin
         w_r = TWO_PI_L - w_r;
      end
      w_neg = 1'b0;
      if (w_r > PI_HALF_L) begin
         w_neg = 1'b1;
         w_r   = PI_L - w_r;
      end
      w_t2  = (w_r * w_r) >>> DEC_BITS;
      w_t4  = (w_t2 * w_t2) >>> DEC_BITS;
      w_t6  = (w_t4 * w_t2) >>> DEC_BITS;
      w_mag = ONE - (w_t2 / 2) + (w_t4 / 24) - (w_t6 / 720);
      if (w_mag < 0) begin
         w_mag = 0;
      end
      o_y = w_neg ? (DEC_BITS+2)'(-w_mag) : (DEC_BITS+2)'(w_mag);
   end

endmodule

// File: rtl/angle_prep.sv
// Turns a sine request into a cosine argument (x - pi/2), folding results
// that fall below the representable range back up by 2*pi.
module angle_prep
   import trig_pkg::*;
#(
   parameter int INT_BITS = INT_BITS_DEF,
   parameter int DEC_BITS = DEC_BITS_DEF
) (
   input  logic signed [INT_BITS+DEC_BITS:0] i_x,
   input  logic                              i_sin,
   output logic signed [INT_BITS+DEC_BITS:0] o_x
);

   localparam int XW = INT_BITS + DEC_BITS + 1;
   localparam logic signed [XW:0] PI_HALF_W = (XW+1)'(piHalfScaled(DEC_BITS));
   localparam logic signed [XW:0] TWO_PI_W  = (XW+1)'(4 * piHalfScaled(DEC_BITS));
   localparam logic signed [XW:0] MIN_X     = {2'b11, {(XW-1){1'b0}}};

   logic signed [XW:0] w_shift;
   logic signed [XW:0] w_wrapped;

   // the subtraction runs one bit wider so an underflow is seen rather than wrapped
   always_comb begin
      w_shift   = {i_x[XW-1], i_x} - PI_HALF_W;
      w_wrapped = w_shift;
      if (w_shift < MIN_X) begin
         w_wrapped = w_shift + TWO_PI_W;
      end
      o_x = i_sin ? XW'(w_wrapped) : i_x;
   end

endmodule

// File: rtl/trig_scheduler.sv
// Two-requester scheduler sharing one combinational Cosine: round-robin grant
// in IDLE, one EVAL cycle, result held in a per-requester output buffer.
module trig_scheduler
   import trig_pkg::*;
#(
   parameter int INT_BITS = INT_BITS_DEF,
   parameter int DEC_BITS = DEC_BITS_DEF
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic                              req0_valid,
   output logic                              req0_ready,
   input  logic signed [INT_BITS+DEC_BITS:0] req0_x,
   input  logic                              req0_sin,
   output logic                              res0_valid,
   input  logic                              res0_ready,
   output logic signed [DEC_BITS+1:0]        res0_y,
   input  logic                              req1_valid,
   output logic                              req1_ready,
   input  logic signed [INT_BITS+DEC_BITS:0] req1_x,
   input  logic                              req1_sin,
   output logic                              res1_valid,
   input  logic                              res1_ready,
   output logic signed [DEC_BITS+1:0]        res1_y
);

   localparam int XW = INT_BITS + DEC_BITS + 1;
   localparam int YW = DEC_BITS + 2;

   state_t               r_state;
   state_t               w_nextState;
   logic signed [XW-1:0] r_x;
   logic                 r_owner;
   logic                 r_last;
   logic                 r_res0Valid;
   logic                 r_res1Valid;
   logic signed [YW-1:0] r_res0Y;
   logic signed [YW-1:0] r_res1Y;

   logic                 w_elig0;
   logic                 w_elig1;
   logic                 w_grant0;
   logic                 w_grant1;
   logic                 w_accept;
   logic signed [XW-1:0] w_selX;
   logic                 w_selSin;
   logic signed [XW-1:0] w_prepX;
   logic signed [YW-1:0] w_cosY;
   logic                 w_write0;
   logic                 w_write1;

   // a full buffer only blocks its own requester, and not if it drains this cycle
   assign w_elig0 = req0_valid & (~r_res0Valid | res0_ready);
   assign w_elig1 = req1_valid & (~r_res1Valid | res1_ready);

   always_comb begin
      w_nextState = r_state;
      w_grant0    = 1'b0;
      w_grant1    = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_elig0 && w_elig1) begin
               w_grant0 = r_last;
               w_grant1 = ~r_last;
            end else begin
               w_grant0 = w_elig0;
               w_grant1 = w_elig1;
            end
            if (w_grant0 || w_grant1) begin
               w_nextState = EVAL;
            end
         end
         EVAL: begin
            w_nextState = IDLE;
         end
      endcase
   end

   assign req0_ready = w_grant0 & rst_n;
   assign req1_ready = w_grant1 & rst_n;
   assign w_accept   = w_grant0 | w_grant1;
   assign w_selX     = w_grant1 ? req1_x : req0_x;
   assign w_selSin   = w_grant1 ? req1_sin : req0_sin;

   angle_prep #(
      .INT_BITS (INT_BITS),
      .DEC_BITS (DEC_BITS)
   ) uPrep (
      .i_x   (w_selX),
      .i_sin (w_selSin),
      .o_x   (w_prepX)
   );

   Cosine #(
      .INT_BITS (INT_BITS),
      .DEC_BITS (DEC_BITS)
   ) uCos (
      .i_x (r_x),
      .o_y (w_cosY)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_x     <= '0;
         r_owner <= 1'b0;
         r_last  <= 1'b1;
      end else begin
         r_state <= w_nextState;
         if (w_accept) begin
            r_x     <= w_prepX;
            r_owner <= w_grant1;
            r_last  <= w_grant1;
         end
      end
   end

   assign w_write0 = (r_state == EVAL) & ~r_owner;
   assign w_write1 = (r_state == EVAL) & r_owner;

   // a write in the same cycle as a consume keeps the buffer full with the new value
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_res0Valid <= 1'b0;
         r_res1Valid <= 1'b0;
         r_res0Y     <= '0;
         r_res1Y     <= '0;
      end else begin
         if (w_write0) begin
            r_res0Valid <= 1'b1;
            r_res0Y     <= w_cosY;
         end else if (res0_ready) begin
            r_res0Valid <= 1'b0;
         end
         if (w_write1) begin
            r_res1Valid <= 1'b1;
            r_res1Y     <= w_cosY;
         end else if (res1_ready) begin
            r_res1Valid <= 1'b0;
         end
      end
   end

   assign res0_valid = r_res0Valid;
   assign res1_valid = r_res1Valid;
   assign res0_y     = r_res0Y;
   assign res1_y     = r_res1Y;

endmodule

// File: tb/tb_trig_scheduler.sv
// Scenario bench for trig_scheduler: a negedge monitor keeps per-requester
// scoreboards fed by reference Cosine instances; each task checks its own scenario.
module tb_trig_scheduler;
   import trig_pkg::*;

   logic               clk = 1'b0;
   logic               rstN;
   logic               req0Valid, req1Valid;
   logic               req0Ready, req1Ready;
   logic signed [12:0] req0X, req1X;
   logic               req0Sin, req1Sin;
   logic               res0Valid, res1Valid;
   logic               res0Ready, res1Ready;
   logic signed [9:0]  res0Y, res1Y;

   logic signed [12:0] refX0, refX1;
   logic signed [9:0]  refY0, refY1;
   logic signed [9:0]  sb0[$];
   logic signed [9:0]  sb1[$];
   logic signed [9:0]  expY;

   int errors = 0;
   int checks = 0;
   int pops0  = 0;
   int pops1  = 0;

   always #5 clk = ~clk;

   function automatic logic signed [12:0] prepModel(input logic signed [12:0] x, input logic s);
      int v;
      v = int'(x);
      if (s) begin
         v = v - 402;
         if (v < -4096) begin
            v = v + 1608;
         end
      end
      return 13'(v);
   endfunction

   trig_scheduler #(.INT_BITS(4), .DEC_BITS(8)) dut (
      .clk        (clk),
      .rst_n      (rstN),
      .req0_valid (req0Valid),
      .req0_ready (req0Ready),
      .req0_x     (req0X),
      .req0_sin   (req0Sin),
      .res0_valid (res0Valid),
      .res0_ready (res0Ready),
      .res0_y     (res0Y),
      .req1_valid (req1Valid),
      .req1_ready (req1Ready),
      .req1_x     (req1X),
      .req1_sin   (req1Sin),
      .res1_valid (res1Valid),
      .res1_ready (res1Ready),
      .res1_y     (res1Y)
   );

   assign refX0 = prepModel(req0X, req0Sin);
   assign refX1 = prepModel(req1X, req1Sin);

   Cosine #(.INT_BITS(4), .DEC_BITS(8)) uRef0 (.i_x(refX0), .o_y(refY0));
   Cosine #(.INT_BITS(4), .DEC_BITS(8)) uRef1 (.i_x(refX1), .o_y(refY1));

   // expected value is captured at the accept handshake, compared at the consume handshake
   always @(negedge clk) begin
      if (rstN) begin
         if (req0Valid && req0Ready) sb0.push_back(refY0);
         if (req1Valid && req1Ready) sb1.push_back(refY1);
         if (res0Valid && res0Ready) begin
            checks++;
            pops0++;
            if (sb0.size() == 0) begin
               errors++;
               $display("[TB] FAIL sb_res0: got res0_y=%0d, expected no result", res0Y);
            end else begin
               expY = sb0.pop_front();
               if (res0Y !== expY) begin
                  errors++;
                  $display("[TB] FAIL sb_res0: res0_y=%0d expected %0d", res0Y, expY);
               end
            end
         end
         if (res1Valid && res1Ready) begin
            checks++;
            pops1++;
            if (sb1.size() == 0) begin
               errors++;
               $display("[TB] FAIL sb_res1: got res1_y=%0d, expected no result", res1Y);
            end else begin
               expY = sb1.pop_front();
               if (res1Y !== expY) begin
                  errors++;
                  $display("[TB] FAIL sb_res1: res1_y=%0d expected %0d", res1Y, expY);
               end
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input int who, input logic valid, input logic signed [12:0] x, input logic s);
      if (who == 0) begin
         req0Valid = valid;
         req0X     = x;
         req0Sin   = s;
      end else begin
         req1Valid = valid;
         req1X     = x;
         req1Sin   = s;
      end
   endtask

   task automatic test_reset();
      rstN = 1'b0;
      applyStimulus(0, 1'b1, 13'd0, 1'b0);
      applyStimulus(1, 1'b1, 13'd0, 1'b0);
      res0Ready = 1'b1;
      res1Ready = 1'b1;
      #2;
      checks++;
      if (req0Ready !== 1'b0 || req1Ready !== 1'b0) begin
         errors++;
         $display("[TB] FAIL reset_ready: ready0=%b ready1=%b expected 0 0", req0Ready, req1Ready);
      end
      tick();
      tick();
      checks++;
      if (res0Valid !== 1'b0 || res1Valid !== 1'b0) begin
         errors++;
         $display("[TB] FAIL reset_valid: valid0=%b valid1=%b expected 0 0", res0Valid, res1Valid);
      end
      checks++;
      if (res0Y !== 10'sd0 || res1Y !== 10'sd0) begin
         errors++;
         $display("[TB] FAIL reset_y: y0=%0d y1=%0d expected 0 0", res0Y, res1Y);
      end
      applyStimulus(0, 1'b0, 13'd0, 1'b0);
      applyStimulus(1, 1'b0, 13'd0, 1'b0);
      #3 rstN = 1'b1;
      tick();
   endtask

   task automatic test_cos_zero();
      applyStimulus(0, 1'b1, 13'd0, 1'b0);
      #2;
      checks++;
      if (req0Ready !== 1'b1 || req1Ready !== 1'b0) begin
         errors++;
         $display("[TB] FAIL first_grant: ready0=%b ready1=%b expected 1 0", req0Ready, req1Ready);
      end
      tick();
      applyStimulus(0, 1'b0, 13'd0, 1'b0);
      checks++;
      if (res0Valid !== 1'b0) begin
         errors++;
         $display("[TB] FAIL latency_early: res0_valid=%b one edge after accept, expected 0", res0Valid);
      end
      tick();
      checks++;
      if (res0Valid !== 1'b1 || res0Y !== 10'sd256) begin
         errors++;
         $display("[TB] FAIL cos_zero: valid=%b y=%0d expected 1 256", res0Valid, res0Y);
      end
      tick();
      checks++;
      if (res0Valid !== 1'b0) begin
         errors++;
         $display("[TB] FAIL consume_clear: res0_valid=%b expected 0", res0Valid);
      end
   endtask

   task automatic test_cos_pi_sin0();
      applyStimulus(1, 1'b1, 13'(804), 1'b0);
      #2;
      checks++;
      if (req1Ready !== 1'b1) begin
         errors++;
         $display("[TB] FAIL pi_grant: ready1=%b expected 1", req1Ready);
      end
      tick();
      applyStimulus(1, 1'b0, 13'd0, 1'b0);
      tick();
      checks++;
      if (res1Valid !== 1'b1 || res1Y > -10'sd250 || res1Y < -10'sd262) begin
         errors++;
         $display("[TB] FAIL cos_pi: valid=%b y=%0d expected 1 and about -256", res1Valid, res1Y);
      end
      tick();
      applyStimulus(0, 1'b1, 13'd0, 1'b1);
      #2;
      checks++;
      if (req0Ready !== 1'b1) begin
         errors++;
         $display("[TB] FAIL sin0_grant: ready0=%b expected 1", req0Ready);
      end
      tick();
      applyStimulus(0, 1'b0, 13'd0, 1'b0);
      tick();
      checks++;
      if (res0Valid !== 1'b1 || res0Y > 10'sd4 || res0Y < -10'sd4) begin
         errors++;
         $display("[TB] FAIL sin_zero: valid=%b y=%0d expected 1 and about 0", res0Valid, res0Y);
      end
      tick();
   endtask

   task automatic test_sin_wrap();
      logic signed [12:0] wantX;
      wantX = 13'(-2890);
      applyStimulus(1, 1'b1, 13'(-4096), 1'b1);
      #2;
      checks++;
      if (req1Ready !== 1'b1) begin
         errors++;
         $display("[TB] FAIL wrap_grant: ready1=%b expected 1", req1Ready);
      end
      tick();
      checks++;
      if (dut.r_x !== wantX) begin
         errors++;
         $display("[TB] FAIL wrap_angle: x_reg=%0d expected %0d", dut.r_x, wantX);
      end
      applyStimulus(1, 1'b0, 13'd100, 1'b0);
      tick();
      checks++;
      if (res1Valid !== 1'b1) begin
         errors++;
         $display("[TB] FAIL wrap_valid: res1_valid=%b expected 1", res1Valid);
      end
      tick();
   endtask

   task automatic test_round_robin();
      int   p0, p1;
      logic want0, want1;
      p0 = pops0;
      p1 = pops1;
      for (int i = 0; i < 8; i++) begin
         applyStimulus(0, 1'b1, 13'($urandom_range(0, 8191)), 1'($urandom_range(0, 1)));
         applyStimulus(1, 1'b1, 13'($urandom_range(0, 8191)), 1'($urandom_range(0, 1)));
         #2;
         want0 = (i % 4 == 0);
         want1 = (i % 4 == 2);
         checks++;
         if (req0Ready !== want0 || req1Ready !== want1) begin
            errors++;
            $display("[TB] FAIL rr_grant cycle %0d: ready0=%b ready1=%b expected %b %b", i, req0Ready, req1Ready, want0, want1);
         end
         tick();
      end
      applyStimulus(0, 1'b0, 13'd0, 1'b0);
      applyStimulus(1, 1'b0, 13'd0, 1'b0);
      tick();
      tick();
      tick();
      checks++;
      if (pops0 - p0 != 2 || pops1 - p1 != 2) begin
         errors++;
         $display("[TB] FAIL rr_results: got %0d/%0d results, expected 2/2", pops0 - p0, pops1 - p1);
      end
   endtask

   task automatic test_blocked();
      int   p0, p1;
      logic want0, want1;
      p0 = pops0;
      p1 = pops1;
      res0Ready = 1'b0;
      for (int i = 0; i < 10; i++) begin
         applyStimulus(0, 1'b1, 13'($urandom_range(0, 8191)), 1'($urandom_range(0, 1)));
         applyStimulus(1, 1'b1, 13'($urandom_range(0, 8191)), 1'($urandom_range(0, 1)));
         #2;
         want0 = (i == 0);
         want1 = (i >= 2) && (i % 2 == 0);
         checks++;
         if (req0Ready !== want0 || req1Ready !== want1) begin
            errors++;
            $display("[TB] FAIL blocked_grant cycle %0d: ready0=%b ready1=%b expected %b %b", i, req0Ready, req1Ready, want0, want1);
         end
         if (i == 5) begin
            checks++;
            if (res0Valid !== 1'b1) begin
               errors++;
               $display("[TB] FAIL blocked_hold: res0_valid=%b expected 1", res0Valid);
            end
         end
         tick();
      end
      res0Ready = 1'b1;
      applyStimulus(0, 1'b1, 13'($urandom_range(0, 8191)), 1'($urandom_range(0, 1)));
      applyStimulus(1, 1'b1, 13'($urandom_range(0, 8191)), 1'($urandom_range(0, 1)));
      #2;
      checks++;
      if (req0Ready !== 1'b1 || req1Ready !== 1'b0) begin
         errors++;
         $display("[TB] FAIL unblock_grant: ready0=%b ready1=%b expected 1 0", req0Ready, req1Ready);
      end
      tick();
      applyStimulus(0, 1'b0, 13'd0, 1'b0);
      applyStimulus(1, 1'b0, 13'd0, 1'b0);
      tick();
      tick();
      tick();
      checks++;
      if (pops0 - p0 != 2 || pops1 - p1 != 4) begin
         errors++;
         $display("[TB] FAIL blocked_results: got %0d/%0d results, expected 2/4", pops0 - p0, pops1 - p1);
      end
   endtask

   task automatic test_reset_mid_eval();
      applyStimulus(0, 1'b1, 13'($urandom_range(0, 8191)), 1'b0);
      #2;
      checks++;
      if (req0Ready !== 1'b1) begin
         errors++;
         $display("[TB] FAIL mid_accept: ready0=%b expected 1", req0Ready);
      end
      tick();
      applyStimulus(0, 1'b0, 13'd0, 1'b0);
      #2 rstN = 1'b0;
      #1;
      checks++;
      if (dut.r_state !== IDLE || res0Valid !== 1'b0 || res1Valid !== 1'b0) begin
         errors++;
         $display("[TB] FAIL mid_reset: state=%0d valid0=%b valid1=%b expected 0 0 0", dut.r_state, res0Valid, res1Valid);
      end
      sb0.delete();
      applyStimulus(0, 1'b1, 13'($urandom_range(0, 8191)), 1'b1);
      applyStimulus(1, 1'b1, 13'($urandom_range(0, 8191)), 1'b0);
      #1;
      checks++;
      if (req0Ready !== 1'b0 || req1Ready !== 1'b0) begin
         errors++;
         $display("[TB] FAIL reset_hold_ready: ready0=%b ready1=%b expected 0 0", req0Ready, req1Ready);
      end
      tick();
      checks++;
      if (res0Valid !== 1'b0 || res1Valid !== 1'b0) begin
         errors++;
         $display("[TB] FAIL reset_hold_valid: valid0=%b valid1=%b expected 0 0", res0Valid, res1Valid);
      end
      #3 rstN = 1'b1;
      #2;
      checks++;
      if (req0Ready !== 1'b1 || req1Ready !== 1'b0) begin
         errors++;
         $display("[TB] FAIL post_reset_grant: ready0=%b ready1=%b expected 1 0", req0Ready, req1Ready);
      end
      tick();
      applyStimulus(0, 1'b0, 13'd0, 1'b0);
      tick();
      #2;
      checks++;
      if (req1Ready !== 1'b1) begin
         errors++;
         $display("[TB] FAIL post_reset_second: ready1=%b expected 1", req1Ready);
      end
      tick();
      applyStimulus(1, 1'b0, 13'd0, 1'b0);
      tick();
      tick();
      tick();
   endtask

   task automatic test_drain();
      checks++;
      if (sb0.size() != 0 || sb1.size() != 0) begin
         errors++;
         $display("[TB] FAIL drain: %0d/%0d results outstanding, expected 0/0", sb0.size(), sb1.size());
      end
   endtask

   initial begin
      test_reset();
      test_cos_zero();
      test_cos_pi_sin0();
      test_sin_wrap();
      test_round_robin();
      test_blocked();
      test_reset_mid_eval();
      test_drain();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation still running at %0t, expected finish", $time);
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
